// File: rtl/paddle_input_ctrl.sv
// paddle_input_ctrl: synchronise, debounce and arbitrate paddle buttons into rate-limited dy pulses.
// Define AI_PLAYER_EN to let ai_mode steer the paddle toward ball_y instead of the buttons.
module paddle_input_ctrl #(
    parameter int BIT_WIDTH       = 10,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MOVE_DIV        = 100000,
    parameter int AI_DEADBAND     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pause,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 ai_mode,
    input  logic [BIT_WIDTH-1:0] ball_y,
    input  logic [BIT_WIDTH-1:0] paddle_y,
    output logic [1:0]           dy,
    output logic                 up_lvl,
    output logic                 down_lvl
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(MOVE_DIV);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(MOVE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } state_t;

    // Bit 0 tracks the up button, bit 1 the down button.
    logic [1:0]          meta_q;
    logic [1:0]          sync_q;
    logic [1:0]          lvl_q;
    logic [1:0]          lvl_d;
    logic [1:0][DW-1:0]  db_cnt_q;
    logic [1:0][DW-1:0]  db_cnt_d;

    logic [TW-1:0]       tick_cnt_q;
    logic [TW-1:0]       tick_cnt_d;
    logic                tick;

    state_t              state_q;
    state_t              state_d;
    state_t              btn_next;
    logic [1:0]          dy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q   <= 2'b00;
            sync_q   <= 2'b00;
            lvl_q    <= 2'b00;
            db_cnt_q <= '0;
        end else begin
            meta_q   <= {btn_down, btn_up};
            sync_q   <= meta_q;
            lvl_q    <= lvl_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    always_comb begin
        lvl_d    = lvl_q;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] != lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    lvl_d[i] = sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // The move divider freezes in place while paused so the cadence resumes seamlessly.
    assign tick = (tick_cnt_q == TICK_LAST) && !pause;

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (!pause) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_d = '0;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    always_comb begin
        btn_next = state_q;
        unique case (state_q)
            IDLE: begin
                if (lvl_q[0] && !lvl_q[1]) begin
                    btn_next = UP;
                end else if (lvl_q[1] && !lvl_q[0]) begin
                    btn_next = DOWN;
                end
            end
            UP: begin
                if (!lvl_q[0]) begin
                    btn_next = lvl_q[1] ? DOWN : IDLE;
                end
            end
            DOWN: begin
                if (!lvl_q[1]) begin
                    btn_next = lvl_q[0] ? UP : IDLE;
                end
            end
            default: btn_next = IDLE;
        endcase
    end

`ifdef AI_PLAYER_EN
    // One extra bit keeps coordinate + deadband from wrapping.
    localparam logic [BIT_WIDTH:0] BAND = (BIT_WIDTH + 1)'(AI_DEADBAND);

    logic [BIT_WIDTH:0] ball_w;
    logic [BIT_WIDTH:0] pad_w;
    state_t             ai_next;

    assign ball_w = {1'b0, ball_y};
    assign pad_w  = {1'b0, paddle_y};

    always_comb begin
        ai_next = IDLE;
        if (ball_w > pad_w + BAND) begin
            ai_next = UP;
        end else if (ball_w + BAND < pad_w) begin
            ai_next = DOWN;
        end
    end

    assign state_d = ai_mode ? ai_next : btn_next;
`else
    logic ai_unused;

    assign ai_unused = ^{ai_mode, ball_y, paddle_y};
    assign state_d   = btn_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dy_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            dy_q    <= tick ? {state_q == DOWN, state_q == UP} : 2'b00;
        end
    end

    assign dy       = dy_q;
    assign up_lvl   = lvl_q[0];
    assign down_lvl = lvl_q[1];

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// tb_paddle_input_ctrl: directed checks of debounce, rate, conflict, pause, reset and AI steering.
// Runs with DEBOUNCE_CYCLES=4, MOVE_DIV=8, AI_DEADBAND=2, BIT_WIDTH=10.
module tb_paddle_input_ctrl;

    logic       clk;
    logic       rst;
    logic       pause;
    logic       btn_up;
    logic       btn_down;
    logic       ai_mode;
    logic [9:0] ball_y;
    logic [9:0] paddle_y;
    logic [1:0] dy;
    logic       up_lvl;
    logic       down_lvl;

    int tests;
    int failed;
    int nu, nd, ng, nw, nb;

    paddle_input_ctrl #(
        .BIT_WIDTH      (10),
        .DEBOUNCE_CYCLES(4),
        .MOVE_DIV       (8),
        .AI_DEADBAND    (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pause   (pause),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .ai_mode (ai_mode),
        .ball_y  (ball_y),
        .paddle_y(paddle_y),
        .dy      (dy),
        .up_lvl  (up_lvl),
        .down_lvl(down_lvl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic watch(input int n, output int n_up, output int n_dn,
                         output int bad_gap, output int wide, output int both);
        int last;
        logic [1:0] prev;
        n_up = 0; n_dn = 0; bad_gap = 0; wide = 0; both = 0;
        last = -1;
        prev = 2'b00;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (dy == 2'b01) n_up++;
            if (dy == 2'b10) n_dn++;
            if (dy == 2'b11) both++;
            if (dy != 2'b00) begin
                if (prev != 2'b00) wide++;
                if (last >= 0 && i - last != 8) bad_gap++;
                last = i;
            end
            prev = dy;
        end
    endtask

    task automatic wait_pulse(input string tag);
        int found;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step(1);
            if (dy != 2'b00) found = 1;
        end
        check(tag, found, 1);
    endtask

    initial begin
        int k;
        int ai_ball [7];
        int ai_exp_up [7];
        int ai_exp_dn [7];

        tests = 0;
        failed = 0;
        rst = 1'b1;
        pause = 1'b0;
        btn_up = 1'b0;
        btn_down = 1'b0;
        ai_mode = 1'b0;
        ball_y = '0;
        paddle_y = '0;

        step(3);
        check("rst_dy", int'(dy), 0);
        check("rst_up_lvl", int'(up_lvl), 0);
        check("rst_down_lvl", int'(down_lvl), 0);
        rst = 1'b0;
        watch(8, nu, nd, ng, nw, nb);
        check("post_rst_pulses", nu + nd + nb, 0);

        btn_up = 1'b1;
        step(3);
        btn_up = 1'b0;
        step(8);
        check("glitch_up_lvl", int'(up_lvl), 0);

        btn_up = 1'b1;
        step(5);
        check("deb_lat5", int'(up_lvl), 0);
        step(1);
        check("deb_lat6", int'(up_lvl), 1);

        step(2);
        watch(64, nu, nd, ng, nw, nb);
        check("rate_up_cnt", nu, 8);
        check("rate_dn_cnt", nd + nb, 0);
        check("rate_gap", ng, 0);
        check("rate_wide", nw, 0);

        btn_down = 1'b1;
        step(8);
        check("conf_down_lvl", int'(down_lvl), 1);
        watch(32, nu, nd, ng, nw, nb);
        check("conf_keep_up", nu, 4);
        check("conf_no_dn", nd + nb, 0);

        btn_up = 1'b0;
        step(8);
        check("conf_up_rel", int'(up_lvl), 0);
        watch(32, nu, nd, ng, nw, nb);
        check("conf_dn_cnt", nd, 4);
        check("conf_dn_no_up", nu + nb, 0);

        btn_down = 1'b0;
        step(8);
        btn_up = 1'b1;
        btn_down = 1'b1;
        step(8);
        check("both_lvls", int'({up_lvl, down_lvl}), 3);
        watch(32, nu, nd, ng, nw, nb);
        check("both_no_pulse", nu + nd + nb, 0);

        btn_up = 1'b0;
        btn_down = 1'b0;
        step(8);
        btn_up = 1'b1;
        step(8);
        wait_pulse("pause_pre_pulse");
        step(3);
        pause = 1'b1;
        watch(20, nu, nd, ng, nw, nb);
        check("pause_quiet", nu + nd + nb, 0);
        pause = 1'b0;
        k = 0;
        for (int i = 1; i <= 12 && k == 0; i++) begin
            step(1);
            if (dy != 2'b00) k = i;
        end
        check("pause_resume_gap", k, 5);
        check("pause_resume_dir", int'(dy), 1);

        wait_pulse("rst_pre_pulse");
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_dy", int'(dy), 0);
        check("async_rst_up_lvl", int'(up_lvl), 0);
        btn_up = 1'b0;
        step(2);
        rst = 1'b0;
        watch(8, nu, nd, ng, nw, nb);
        check("rst_mid_quiet", nu + nd + nb, 0);

        ai_ball = '{110, 90, 101, 102, 98, 103, 97};
`ifdef AI_PLAYER_EN
        ai_exp_up = '{2, 0, 0, 0, 0, 2, 0};
        ai_exp_dn = '{0, 2, 0, 0, 0, 0, 2};
`else
        ai_exp_up = '{0, 0, 0, 0, 0, 0, 0};
        ai_exp_dn = '{0, 0, 0, 0, 0, 0, 0};
`endif
        ai_mode = 1'b1;
        paddle_y = 10'd100;
        for (int i = 0; i < 7; i++) begin
            ball_y = 10'(ai_ball[i]);
            step(2);
            watch(16, nu, nd, ng, nw, nb);
            check($sformatf("ai_up_%0d", ai_ball[i]), nu, ai_exp_up[i]);
            check($sformatf("ai_dn_%0d", ai_ball[i]), nd + nb, ai_exp_dn[i]);
        end
        ai_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
